// File: rtl/timer_run_ctrl.sv
// timer_run_ctrl: start/pause/clear/limit control FSM for the h/m/s up-counter timer.
// Optional lap capture is built only when TIMER_RUN_CTRL_LAP_EN is defined.
module timer_run_ctrl #(
  parameter logic [5:0] LIMIT_H = 6'd1,
  parameter logic [5:0] LIMIT_M = 6'd0,
  parameter logic [5:0] LIMIT_S = 6'd0
) (
  input  logic       clk_1Hz,
  input  logic       rst_n,
  input  logic       power_on,
  input  logic       start_req,
  input  logic       pause_req,
  input  logic       clear_req,
  input  logic       lap_req,
  input  logic [5:0] t_hour,
  input  logic [5:0] t_min,
  input  logic [5:0] t_sec,
  output logic       start_timer,
  output logic       timer_clr,
  output logic [1:0] state,
  output logic       limit_reached,
  output logic [5:0] lap_hour,
  output logic [5:0] lap_min,
  output logic [5:0] lap_sec
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t cur_state, next_state;
  logic   clr_next;
  logic   at_limit;

  assign at_limit = (t_hour == LIMIT_H) && (t_min == LIMIT_M) && (t_sec == LIMIT_S);

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      timer_clr <= 1'b0;
    end else begin
      cur_state <= next_state;
      timer_clr <= clr_next;
    end
  end

  // Power-off outranks clear, which outranks every per-state request.
  always_comb begin
    next_state = cur_state;
    clr_next   = 1'b0;
    if (!power_on || clear_req) begin
      next_state = IDLE;
      clr_next   = 1'b1;
    end else begin
      unique case (cur_state)
        IDLE:  if (start_req) next_state = RUN;
        RUN: begin
          if (pause_req)     next_state = PAUSE;
          else if (at_limit) next_state = DONE;
        end
        PAUSE: if (start_req) next_state = RUN;
        DONE:  next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Gating on at_limit freezes the timer on the limit value itself.
  assign start_timer   = (cur_state == RUN) && !at_limit;
  assign state         = cur_state;
  assign limit_reached = (cur_state == DONE);

`ifdef TIMER_RUN_CTRL_LAP_EN
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      lap_hour <= 6'd0;
      lap_min  <= 6'd0;
      lap_sec  <= 6'd0;
    end else if (!power_on || clear_req) begin
      lap_hour <= 6'd0;
      lap_min  <= 6'd0;
      lap_sec  <= 6'd0;
    end else if (lap_req) begin
      if (cur_state == RUN || cur_state == PAUSE) begin
        lap_hour <= t_hour;
        lap_min  <= t_min;
        lap_sec  <= t_sec;
      end else if (cur_state == DONE) begin
        lap_hour <= LIMIT_H;
        lap_min  <= LIMIT_M;
        lap_sec  <= LIMIT_S;
      end
    end
  end
`else
  logic unused_lap_req;
  assign unused_lap_req = lap_req;
  assign lap_hour = 6'd0;
  assign lap_min  = 6'd0;
  assign lap_sec  = 6'd0;
`endif

endmodule
